uart_alu_pkt_ctrl: RTL and testbench



---
 rtl/uart_alu_pkg.sv | 31 +++
 rtl/pkt_timeout_ctr.sv | 27 ++
 rtl/uart_alu_pkt_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_alu_pkt_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and helpers for the framed UART-to-ALU packet controller.
package uart_alu_pkg;

    // Controller states. ST_SEND covers both the busy test and the guard cycle.
    typedef enum logic [3:0] {
        ST_LOCKED  = 4'd0,
        ST_HUNT    = 4'd1,
        ST_GET_OP  = 4'd2,
        ST_GET_A   = 4'd3,
        ST_GET_B   = 4'd4,
        ST_GET_CHK = 4'd5,
        ST_EXEC    = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_ERR     = 4'd8,
        ST_SEND    = 4'd9
    } state_t;

    // Bit positions inside the response STATUS byte; [3:0] carry the ALU flags.
    localparam int STAT_OK  = 7;
    localparam int STAT_TO  = 6;
    localparam int STAT_PAR = 5;
    localparam int STAT_CHK = 4;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // XOR of the four bytes of a word; narrower operands are zero-extended first.
    function automatic logic [7:0] xor_fold(input logic [31:0] v);
        return v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
    endfunction

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Inter-byte cycle counter: clear wins over enable, expired holds until cleared.
module pkt_timeout_ctr #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles since the last clear, saturating at the expire point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_alu_pkt_ctrl.sv
// Framed UART command controller: parses SYNC/OP/A/B/CHK packets, drives an
// external combinational ALU and returns STATUS/RESULT/RCHK responses.
module uart_alu_pkt_ctrl
    import uart_alu_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter int         OP_W        = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_parity_err,
    input  logic              auth,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              pkt_ok,
    output logic              pkt_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = 3;   // covers operand index NB-1 and response index NB+2

    state_t            state;
    logic [DATA_W-1:0] sh_a, sh_b;
    logic [OP_W-1:0]   sh_sel;
    logic [7:0]        chk_acc;
    logic [IDX_W-1:0]  idx;
    logic              guard;
    logic [2:0]        err_bits;     // {timeout, parity, checksum}
    logic [7:0]        resp_status;
    logic [DATA_W-1:0] resp_result;

    logic              in_get;
    logic              tmo_expired;
    logic [7:0]        cap_status;
    logic [7:0]        err_status;
    logic [7:0]        cur_byte;
    logic [DATA_W-1:0] shifted;

    // Timeout runs only while a packet body is being collected.
    assign in_get = (state == ST_GET_OP) || (state == ST_GET_A) ||
                    (state == ST_GET_B)  || (state == ST_GET_CHK);

    pkt_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (rx_valid || !in_get),
        .en      (in_get),
        .expired (tmo_expired)
    );

    // STATUS bytes for the success and error paths, built from current inputs/flags.
    always_comb begin
        cap_status           = '0;
        cap_status[STAT_OK]  = 1'b1;
        cap_status[3:0]      = alu_flags;
        err_status           = '0;
        err_status[STAT_TO]  = err_bits[2];
        err_status[STAT_PAR] = err_bits[1];
        err_status[STAT_CHK] = err_bits[0];
    end

    // Response byte selected by idx: STATUS, result bytes MSB first, then RCHK.
    always_comb begin
        shifted  = '0;
        cur_byte = resp_status;
        if (idx != '0 && idx <= IDX_W'(NB)) begin
            shifted  = resp_result >> (8 * (NB - int'(idx)));
            cur_byte = shifted[7:0];
        end else if (idx > IDX_W'(NB)) begin
            cur_byte = resp_status ^ xor_fold(32'(resp_result));
        end
    end

    // Main packet FSM; all outputs registered. Byte 0 of a response is launched
    // straight from CAPTURE/ERR so the first tx_start lands the cycle after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_LOCKED;
            sh_a        <= '0;
            sh_b        <= '0;
            sh_sel      <= '0;
            chk_acc     <= '0;
            idx         <= '0;
            guard       <= 1'b0;
            err_bits    <= '0;
            resp_status <= '0;
            resp_result <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            pkt_ok      <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;

            if (!auth && state != ST_SEND) begin
                // Lock drops the packet in flight without any response.
                state <= ST_LOCKED;
                busy  <= 1'b0;
                guard <= 1'b0;
            end else begin
                case (state)
                    ST_LOCKED: state <= ST_HUNT;

                    ST_HUNT: begin
                        if (rx_valid && !rx_parity_err && rx_data == SYNC_BYTE) begin
                            busy  <= 1'b1;
                            state <= ST_GET_OP;
                        end
                    end

                    ST_GET_OP, ST_GET_A, ST_GET_B, ST_GET_CHK: begin
                        if (rx_valid && rx_parity_err) begin
                            err_bits <= 3'b010;
                            state    <= ST_ERR;
                        end else if (rx_valid) begin
                            // An arriving byte beats a same-cycle timeout.
                            case (state)
                                ST_GET_OP: begin
                                    sh_sel  <= rx_data[OP_W-1:0];
                                    chk_acc <= rx_data;
                                    idx     <= IDX_W'(NB - 1);
                                    state   <= ST_GET_A;
                                end
                                ST_GET_A: begin
                                    sh_a    <= (sh_a << 8) | DATA_W'(rx_data);
                                    chk_acc <= chk_acc ^ rx_data;
                                    if (idx == '0) begin
                                        idx   <= IDX_W'(NB - 1);
                                        state <= ST_GET_B;
                                    end else begin
                                        idx <= idx - IDX_W'(1);
                                    end
                                end
                                ST_GET_B: begin
                                    sh_b    <= (sh_b << 8) | DATA_W'(rx_data);
                                    chk_acc <= chk_acc ^ rx_data;
                                    if (idx == '0)
                                        state <= ST_GET_CHK;
                                    else
                                        idx <= idx - IDX_W'(1);
                                end
                                default: begin
                                    if (rx_data == chk_acc) begin
                                        state <= ST_EXEC;
                                    end else begin
                                        err_bits <= 3'b001;
                                        state    <= ST_ERR;
                                    end
                                end
                            endcase
                        end else if (tmo_expired) begin
                            err_bits <= 3'b100;
                            state    <= ST_ERR;
                        end
                    end

                    ST_EXEC: begin
                        alu_a   <= sh_a;
                        alu_b   <= sh_b;
                        alu_sel <= sh_sel;
                        state   <= ST_CAPTURE;
                    end

                    ST_CAPTURE, ST_ERR: begin
                        if (state == ST_CAPTURE) begin
                            resp_status <= cap_status;
                            resp_result <= alu_result;
                        end else begin
                            resp_status <= err_status;
                            resp_result <= '0;
                        end
                        state <= ST_SEND;
                        if (!tx_busy) begin
                            tx_data  <= (state == ST_CAPTURE) ? cap_status : err_status;
                            tx_start <= 1'b1;
                            idx      <= IDX_W'(1);
                            guard    <= 1'b1;
                        end else begin
                            idx   <= '0;
                            guard <= 1'b0;
                        end
                    end

                    ST_SEND: begin
                        if (guard) begin
                            // Guard cycle lets tx_busy rise before the next test.
                            guard <= 1'b0;
                            if (idx == IDX_W'(NB + 2)) begin
                                pkt_ok  <= resp_status[STAT_OK];
                                pkt_err <= !resp_status[STAT_OK];
                                busy    <= 1'b0;
                                state   <= auth ? ST_HUNT : ST_LOCKED;
                            end
                        end else if (!tx_busy) begin
                            tx_data  <= cur_byte;
                            tx_start <= 1'b1;
                            idx      <= idx + IDX_W'(1);
                            guard    <= 1'b1;
                        end
                    end

                    default: state <= ST_LOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_pkt_ctrl.sv
// Directed bench for uart_alu_pkt_ctrl with a small ALU and transmitter model.
module tb_uart_alu_pkt_ctrl;
    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_parity_err;
    logic              auth;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]   alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic              busy, pkt_ok, pkt_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_alu_pkt_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .auth(auth), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_result(alu_result), .alu_flags(alu_flags),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    // Bench ALU: op0 = add with carry, anything else = AND.
    logic [DATA_W:0] sum;
    logic            carry;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_a & alu_b;
        carry      = 1'b0;
        if (alu_sel == 4'd0) begin
            alu_result = sum[DATA_W-1:0];
            carry      = sum[DATA_W];
        end
        alu_flags = {2'b00, alu_result == '0, carry};
    end

    // Transmitter model: logs each started byte and stays busy for four cycles.
    logic [7:0] txq[$];
    int busy_cnt = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    always @(posedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            tx_busy  <= 1'b1;
            busy_cnt <= 4;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
        if (pkt_ok)  ok_cnt  = ok_cnt + 1;
        if (pkt_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; rx_parity_err = par;
        @(negedge clk);
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    // Sends a full packet; optionally checks EXEC/CAPTURE timing after the CHK byte.
    task automatic send_pkt(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] chk, input bit lat_chk);
        send_byte(8'hA5, 1'b0);
        send_byte(op, 1'b0);
        send_byte(a[15:8], 1'b0);
        send_byte(a[7:0], 1'b0);
        send_byte(b[15:8], 1'b0);
        send_byte(b[7:0], 1'b0);
        send_byte(chk, 1'b0);
        if (lat_chk) begin
            @(negedge clk);
            check("capture_cycle_no_start", tx_start, 0);
            check("exec_loaded_a", alu_a, a);
            @(negedge clk);
            check("first_start_latency", tx_start, 1);
        end
    endtask

    // Waits (bounded) for a pkt_ok/pkt_err pulse beyond the given baseline.
    task automatic wait_resp(input string tag, input int base_done);
        int n = 0;
        while (ok_cnt + err_cnt == base_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(ok_cnt + err_cnt != base_done), 1);
    endtask

    task automatic check_resp(input string tag, input int base_tx, input logic [31:0] exp);
        logic [7:0] g;
        check({tag, "_nbytes"}, 32'(txq.size() - base_tx), 4);
        for (int i = 0; i < 4; i++) begin
            g = (base_tx + i < txq.size()) ? txq[base_tx + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp[31 - 8*i -: 8]));
        end
    endtask

    int bt, bd, bo, be, n;

    initial begin
        reset = 1'b0; auth = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_parity_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_pkt", {pkt_ok, pkt_err}, 0);
        reset = 1'b1; auth = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good add packet
        bt = txq.size(); bd = ok_cnt + err_cnt; bo = ok_cnt; be = err_cnt;
        send_pkt(8'h00, 16'h1234, 16'h0005, 8'h23, 1'b1);
        wait_resp("t1", bd);
        check_resp("t1", bt, 32'h801239AB);
        check("t1_ok", ok_cnt - bo, 1);
        check("t1_err", err_cnt - be, 0);
        check("t1_alu_a", alu_a, 32'h1234);
        check("t1_alu_b", alu_b, 32'h0005);
        check("t1_busy_after", busy, 0);

        // 2: checksum error keeps ALU operands
        bt = txq.size(); bd = ok_cnt + err_cnt; be = err_cnt;
        send_pkt(8'h00, 16'h1234, 16'h0005, 8'h24, 1'b0);
        wait_resp("t2", bd);
        check_resp("t2", bt, 32'h10000010);
        check("t2_err", err_cnt - be, 1);
        check("t2_alu_a", alu_a, 32'h1234);
        check("t2_alu_b", alu_b, 32'h0005);

        // carry/zero flags: FFFF + 0001
        bt = txq.size(); bd = ok_cnt + err_cnt;
        send_pkt(8'h00, 16'hFFFF, 16'h0001, 8'h01, 1'b0);
        wait_resp("tflags", bd);
        check_resp("tflags", bt, 32'h83000083);

        // 3: inter-byte timeout
        bt = txq.size(); bd = ok_cnt + err_cnt; be = err_cnt;
        send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_no_early_timeout", 32'(txq.size() - bt), 0);
        wait_resp("t3", bd);
        check_resp("t3", bt, 32'h40000040);
        check("t3_err", err_cnt - be, 1);

        // parity error mid-packet
        bt = txq.size(); bd = ok_cnt + err_cnt;
        send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b1);
        wait_resp("tpar", bd);
        check_resp("tpar", bt, 32'h20000020);

        // 4: junk before sync gives exactly one response
        bt = txq.size(); bd = ok_cnt + err_cnt;
        send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0);
        send_pkt(8'h00, 16'h1234, 16'h0005, 8'h23, 1'b0);
        wait_resp("t4", bd);
        repeat (60) @(negedge clk);
        check_resp("t4", bt, 32'h801239AB);
        check("t4_one_pulse", ok_cnt + err_cnt - bd, 1);

        // 5: auth drop mid-packet
        bt = txq.size(); bd = ok_cnt + err_cnt;
        send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h12, 1'b0);
        check("t5_busy_in_pkt", busy, 1);
        auth = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_locked", busy, 0);
        repeat (TMO + 20) @(negedge clk);
        check("t5_no_tx", 32'(txq.size() - bt), 0);
        check("t5_no_pulse", ok_cnt + err_cnt - bd, 0);
        auth = 1'b1;
        repeat (2) @(negedge clk);
        send_pkt(8'h00, 16'h1234, 16'h0005, 8'h23, 1'b0);
        wait_resp("t5", bd);
        check_resp("t5", bt, 32'h801239AB);

        // 6: reset during SEND
        repeat (10) @(negedge clk);
        send_pkt(8'h00, 16'h1234, 16'h0005, 8'h23, 1'b0);
        n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        check("t6_saw_start", tx_start, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rst_tx_data", tx_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_alu_a", alu_a, 0);
        check("t6_rst_alu_b", alu_b, 0);
        check("t6_rst_outs", {tx_start, pkt_ok, pkt_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bt = txq.size(); bd = ok_cnt + err_cnt;
        repeat (60) @(negedge clk);
        check("t6_no_tx_after", 32'(txq.size() - bt), 0);
        check("t6_no_pulse_after", ok_cnt + err_cnt - bd, 0);
        check("t6_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
